// File: rtl/uart_pkg.sv
// Shared constants, state encoding and payload types for the APU-register UART transmitter.
package uart_pkg;

   localparam int unsigned BAUD_DIV   = 5;
   localparam int unsigned FRAME_BITS = 10;
   localparam int unsigned DATA_BITS  = FRAME_BITS - 2;

   localparam logic [2:0] SEL_4000 = 3'd0;
   localparam logic [2:0] SEL_4001 = 3'd1;
   localparam logic [2:0] SEL_4002 = 3'd2;
   localparam logic [2:0] SEL_4003 = 3'd3;
   localparam logic [2:0] SEL_4007 = 3'd4;
   localparam logic [2:0] SEL_4008 = 3'd5;
   localparam logic [2:0] SEL_400A = 3'd6;
   localparam logic [2:0] SEL_400B = 3'd7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   typedef struct packed {
      logic [2:0] sel;
      logic [7:0] data;
   } wr_req_t;

   // Frame byte: address {sel, frame} in the high nibble, selected data nibble low.
   function automatic logic [7:0] frame_byte(input wr_req_t req, input logic frame);
      return frame ? {req.sel, 1'b1, req.data[7:4]} : {req.sel, 1'b0, req.data[3:0]};
   endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period divider: counts 0..DIV-1 while enabled, held at 0 otherwise.
module baud_tick #(
   parameter int unsigned DIV = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt <= '0;
      end else if (cnt == CW'(DIV - 1)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = en && (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_tx.sv
// Serializes one APU register write into two 8N1 frames (address/low nibble, address+1/high nibble).
module uart_tx #(
   parameter int unsigned BAUD_DIV  = uart_pkg::BAUD_DIV,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_valid,
   input  logic [2:0] wr_sel,
   input  logic [7:0] wr_data,
   output logic       wr_ready,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   import uart_pkg::*;

   tx_state_e  state_q, state_d;
   wr_req_t    req_q, req_d;
   logic       frame_q, frame_d;
   logic [2:0] bit_q, bit_d;
   logic [1:0] stop_q, stop_d;
   logic       tx_q, tx_d;
   logic       done_q, done_d;
   logic       ready_q, busy_q;
   logic       tick;
   logic [7:0] cur_byte;

   baud_tick #(.DIV(BAUD_DIV)) u_baud_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q != IDLE),
      .tick (tick)
   );

   assign cur_byte = frame_byte(req_q, frame_q);

   // Next-state logic; tx_d is the bit that will be on the pin next cycle.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      frame_d = frame_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (wr_valid) begin
               req_d   = '{sel: wr_sel, data: wr_data};
               frame_d = 1'b0;
               bit_d   = 3'd0;
               stop_d  = 2'd0;
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (tick) begin
               state_d = DATA;
               bit_d   = 3'd0;
               tx_d    = cur_byte[0];
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_q == 3'(DATA_BITS - 1)) begin
                  state_d = STOP;
                  stop_d  = 2'd0;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = cur_byte[bit_q + 3'd1];
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (stop_q == 2'(STOP_BITS - 1)) begin
                  if (!frame_q) begin
                     frame_d = 1'b1;
                     state_d = START;
                     tx_d    = 1'b0;
                  end else begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                     tx_d    = 1'b1;
                  end
               end else begin
                  stop_d = stop_q + 2'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= '0;
         frame_q <= 1'b0;
         bit_q   <= 3'd0;
         stop_q  <= 2'd0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         frame_q <= frame_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         ready_q <= (state_d == IDLE);
         busy_q  <= (state_d != IDLE);
      end
   end

   assign tx       = tx_q;
   assign done     = done_q;
   assign wr_ready = ready_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: per-cycle expected waveform queue plus a frame-level register decoder.
module tb_uart_tx;

   localparam int BD   = 5;
   localparam int TXN1 = 2 * (9 + 1) * BD;
   localparam int TXN2 = 2 * (9 + 2) * BD;

   logic       clk = 1'b0;
   logic       rst, wr_valid, v2;
   logic [2:0] wr_sel;
   logic [7:0] wr_data;
   logic       wr_ready, tx, busy, done;
   logic       ready2, tx2, busy2, done2;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit tx;
      bit last;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       cur;
   logic [7:0] model_reg[8];
   logic [7:0] dec_reg[8];
   logic [7:0] rx_log[$];
   bit         mon_en = 1'b0;
   bit         expect_done = 1'b0;
   bit         rst_seen = 1'b0;
   int         low_cnt = 0;

   bit         rx_act = 1'b0;
   int         rx_pos = 0;
   int         bit_idx;
   logic [7:0] rx_byte = '0;
   logic [7:0] first_b = '0;
   bit         have_first = 1'b0;

   always #5 clk = ~clk;

   uart_tx dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_data(wr_data),
      .wr_ready(wr_ready), .tx(tx), .busy(busy), .done(done)
   );

   uart_tx #(.STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .wr_valid(v2), .wr_sel(wr_sel), .wr_data(wr_data),
      .wr_ready(ready2), .tx(tx2), .busy(busy2), .done(done2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference line level for sample idx of a transaction, from the frame rules alone.
   function automatic bit wave_bit(input int s, input int d, input int sb, input int idx);
      int flen, f, pos, b;
      flen = (9 + sb) * BD;
      f    = idx / flen;
      pos  = (idx % flen) / BD;
      b    = (2 * s + f) * 16 + ((f == 1) ? d / 16 : d % 16);
      if (pos == 0) return 1'b0;
      if (pos <= 8) return bit'((b >> (pos - 1)) & 1);
      return 1'b1;
   endfunction

   task automatic issue(input logic [2:0] s, input logic [7:0] d, input bit commit);
      bit acc;
      int n;
      wr_valid = 1'b1;
      wr_sel   = s;
      wr_data  = d;
      acc      = 1'b0;
      n        = 0;
      while (!acc && n < 300) begin
         @(negedge clk);
         acc = wr_ready && !rst;
         @(posedge clk);
         n++;
      end
      if (acc) begin
         for (int i = 0; i < TXN1; i++)
            exp_q.push_back('{tx: wave_bit(int'(s), int'(d), 1, i), last: (i == TXN1 - 1)});
         if (commit) model_reg[s] = d;
      end else begin
         chk("accept_timeout", 32'(acc), 32'd1);
      end
      #1;
      wr_valid = 1'b0;
   endtask

   task automatic wait_idle(input bit tog);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         if (tog) begin
            wr_data = 8'($urandom);
            wr_sel  = 3'($urandom);
         end
         n++;
      end while (!wr_ready && n < 400);
      if (!wr_ready) chk("idle_timeout", 32'(wr_ready), 32'd1);
   endtask

   task automatic check_regs();
      for (int i = 0; i < 8; i++)
         chk($sformatf("reg_sel%0d", i), 32'(dec_reg[i]), 32'(model_reg[i]));
   endtask

   // Reset aborts everything in flight.
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         expect_done = 1'b0;
         if (low_cnt > 0) rst_seen = 1'b1;
      end
   end

   // Per-cycle monitor against the scoreboard queue.
   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("tx_bit", 32'(tx), 32'(cur.tx));
            chk("busy_status", 32'({wr_ready, busy, done}), 32'b010);
            expect_done = cur.last;
         end else begin
            chk("tx_idle", 32'(tx), 32'd1);
            chk("idle_status", 32'({wr_ready, busy, done}), 32'({2'b10, expect_done}));
            expect_done = 1'b0;
         end
         if (!wr_ready) begin
            low_cnt++;
         end else if (low_cnt > 0) begin
            if (!rst_seen) chk("ready_low_cycles", 32'(low_cnt), 32'(TXN1));
            low_cnt  = 0;
            rst_seen = 1'b0;
         end
      end
   end

   // Frame-level receiver and APU register decoder on the tx line.
   always @(negedge clk) begin
      if (mon_en) begin
         if (rst) begin
            rx_act     = 1'b0;
            have_first = 1'b0;
         end else if (!rx_act) begin
            if (tx == 1'b0) begin
               rx_act = 1'b1;
               rx_pos = 0;
            end
         end else begin
            rx_pos++;
            if (rx_pos % BD == BD / 2) begin
               bit_idx = rx_pos / BD;
               if (bit_idx == 0) chk("start_bit", 32'(tx), 32'd0);
               if (bit_idx >= 1 && bit_idx <= 8) rx_byte[bit_idx - 1] = tx;
               if (bit_idx == 9) begin
                  rx_act = 1'b0;
                  chk("stop_bit", 32'(tx), 32'd1);
                  rx_log.push_back(rx_byte);
                  if (!rx_byte[4]) begin
                     first_b    = rx_byte;
                     have_first = 1'b1;
                  end else begin
                     chk("frame_pair", 32'({have_first, rx_byte[7:5]}), 32'({1'b1, first_b[7:5]}));
                     if (have_first) dec_reg[rx_byte[7:5]] = {rx_byte[3:0], first_b[3:0]};
                     have_first = 1'b0;
                  end
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d2;
      rst      = 1'b1;
      wr_valid = 1'b0;
      v2       = 1'b0;
      wr_sel   = 3'd0;
      wr_data  = 8'd0;
      for (int i = 0; i < 8; i++) begin
         model_reg[i] = 8'h00;
         dec_reg[i]   = 8'h00;
      end
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      chk("reset_state", 32'({tx, wr_ready, busy, done}), 32'b1100);
      @(posedge clk);
      #1;

      // $4000 = $A5: bytes $05 then $1A
      rx_log.delete();
      issue(3'd0, 8'hA5, 1'b1);
      wait_idle(1'b0);
      chk("rx_frame_count", 32'(rx_log.size()), 32'd2);
      if (rx_log.size() == 2) begin
         chk("frame1_byte", 32'(rx_log[0]), 32'h05);
         chk("frame2_byte", 32'(rx_log[1]), 32'h1A);
      end

      // $400B = $3C
      issue(3'd7, 8'h3C, 1'b1);
      wait_idle(1'b0);
      check_regs();

      // eight back-to-back writes
      for (int s = 0; s < 8; s++) issue(3'(s), 8'(8'h11 * (s + 1)), 1'b1);
      wait_idle(1'b0);
      check_regs();

      // reset in cycle 37 of a transaction
      issue(3'd5, 8'h5A, 1'b0);
      repeat (36) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_tx_high", 32'(tx), 32'd1);
      issue(3'd2, 8'hFF, 1'b1);
      wait_idle(1'b0);
      check_regs();

      // request held during reset is ignored
      rst      = 1'b1;
      wr_valid = 1'b1;
      wr_sel   = 3'd3;
      wr_data  = 8'h77;
      repeat (3) @(posedge clk);
      #1;
      rst      = 1'b0;
      wr_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("no_accept_in_rst", 32'({busy, tx}), 32'b01);

      // inputs churn while busy
      issue(3'd4, 8'($urandom), 1'b1);
      wait_idle(1'b1);
      check_regs();

      // randomized writes, mixed back-to-back and gaps
      for (int n = 0; n < 20; n++) begin
         issue(3'($urandom_range(0, 7)), 8'($urandom), 1'b1);
         if ($urandom_range(0, 2) == 0) begin
            wait_idle(1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
      end
      wait_idle(1'b0);
      check_regs();

      // two stop bits: 110-cycle transaction
      wr_sel  = 3'd6;
      d2      = 8'($urandom);
      wr_data = d2;
      v2      = 1'b1;
      @(negedge clk);
      chk("dut2_ready", 32'(ready2), 32'd1);
      @(posedge clk);
      #1;
      v2 = 1'b0;
      for (int i = 0; i < TXN2; i++) begin
         @(negedge clk);
         chk("dut2_tx", 32'(tx2), 32'(wave_bit(6, int'(d2), 2, i)));
         chk("dut2_busy", 32'({ready2, busy2, done2}), 32'b010);
      end
      @(negedge clk);
      chk("dut2_done", 32'({ready2, busy2, done2}), 32'b101);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
